// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT definitions (sample width, complex field slices, output FSM states)
package fft_pkg;
  localparam int WORD_SIZE = 32;
  localparam int RE_MSB = WORD_SIZE - 1;
  localparam int IM_MSB = WORD_SIZE / 2 - 1;
  typedef enum logic {IDLE, HOLD} out_state_e;
endpackage

// File: rtl/fft_hold_timer.sv
// fft_hold_timer: loadable down-counter that saturates at zero
//   clk, rst_n : clock, async active-low reset
//   load       : load value into the counter this edge
//   value      : count to load
//   zero       : counter is currently zero
module fft_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? value : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: collects N streamed complex samples and holds each frame on the FFT input bus
//   clk, rst_n   : clock, async active-low reset
//   s_data       : complex sample (real in upper half, imag in lower half)
//   s_valid      : s_data valid
//   s_last       : closes a short frame (only with FFT_FRAMER_TLAST_EN defined)
//   s_ready      : framer accepts s_data this cycle
//   frame        : flattened frame, sample k at [k*WORD_SIZE +: WORD_SIZE]
//   frame_valid  : pulse in the first cycle of a new frame
//   frame_busy   : frame is being held for HOLD_CYCLES cycles
//   frame_err    : sticky malformed-frame flag (FFT_FRAMER_TLAST_EN only, else 0)
// Optional feature macro: FFT_FRAMER_TLAST_EN
module fft_input_framer #(
  parameter int N           = 8,
  parameter int WORD_SIZE   = fft_pkg::WORD_SIZE,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WORD_SIZE-1:0]   s_data,
  input  logic                   s_valid,
`ifdef FFT_FRAMER_TLAST_EN
  input  logic                   s_last,
`endif
  output logic                   s_ready,
  output logic [N*WORD_SIZE-1:0] frame,
  output logic                   frame_valid,
  output logic                   frame_busy,
  output logic                   frame_err
);
  import fft_pkg::*;
  localparam int IO_SIZE = N * WORD_SIZE;
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IO_SIZE-1:0] fill_buf_q, fill_buf_d, frame_q, frame_d;
  logic fill_full_q, fill_full_d;
  logic frame_valid_q, frame_valid_d, frame_busy_q, frame_busy_d, frame_err_q, frame_err_d;
  out_state_e state_q, state_d;
  logic accept, publish, last_slot, hold_zero;
  assign s_ready = !fill_full_q;
  assign accept = s_valid && s_ready;
  assign publish = state_q == IDLE && fill_full_q;
  assign last_slot = wr_idx_q == IW'(N - 1);
  fft_hold_timer #(.W(HW)) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (publish),
    .value(HW'(HOLD_CYCLES - 1)),
    .zero (hold_zero)
  );
  // accept needs fill_full low and publish needs it high, so the two never share an edge
  always_comb begin
    wr_idx_d = wr_idx_q;
    fill_buf_d = fill_buf_q;
    fill_full_d = fill_full_q && !publish;
    frame_err_d = frame_err_q;
    if (accept) begin
      fill_buf_d[wr_idx_q*WORD_SIZE +: WORD_SIZE] = s_data;
      wr_idx_d = last_slot ? '0 : wr_idx_q + IW'(1);
      fill_full_d = last_slot;
`ifdef FFT_FRAMER_TLAST_EN
      if (s_last && !last_slot) begin
        for (int k = 0; k < N; k++)
          if (k > int'(wr_idx_q)) fill_buf_d[k*WORD_SIZE +: WORD_SIZE] = '0;
        wr_idx_d = '0;
        fill_full_d = 1'b1;
      end
      if (last_slot && !s_last) frame_err_d = 1'b1;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    frame_valid_d = 1'b0;
    if (publish) begin
      state_d = HOLD;
      frame_d = fill_buf_q;
      frame_valid_d = 1'b1;
    end else if (state_q == HOLD && hold_zero) begin
      state_d = IDLE;
    end
    frame_busy_d = state_d == HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      fill_buf_q <= '0;
      fill_full_q <= 1'b0;
      state_q <= IDLE;
      frame_q <= '0;
      frame_valid_q <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      fill_buf_q <= fill_buf_d;
      fill_full_q <= fill_full_d;
      state_q <= state_d;
      frame_q <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_busy_q <= frame_busy_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign frame = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_busy = frame_busy_q;
  assign frame_err = frame_err_q;
endmodule
